// File: rtl/spi_controller_master.sv
// spi_controller_master
//   SPI initiator: turns one register read/write request into a single
//   CS-framed SPI transaction (8-bit command + REG_WIDTH data bits, MSB first)
//   in any of the four CPOL/CPHA modes, and returns the MISO bits captured
//   during the data field.
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   mode[1:0]           {cpol,cpha}, latched when a request is accepted
//   req_valid/ready     request handshake; ready is high only while idle
//   req_write/addr/wdata request fields
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           data-field MISO samples, held until the next rsp_valid
//   spi_cs_n/clk/mosi   SPI outputs (all registered)
//   spi_miso            SPI input
module spi_controller_master #(
  parameter int CLK_DIV    = 4,
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [REG_WIDTH-1:0]  req_wdata,
  output logic                  rsp_valid,
  output logic [REG_WIDTH-1:0]  rsp_rdata,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int FB = 8 + REG_WIDTH;          // frame bits
  localparam int NE = 2 * FB;                 // SCLK edges per frame
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EW = $clog2(NE + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t               state;
  logic [DW-1:0]        div_cnt;
  logic [EW-1:0]        edge_cnt;
  logic [FB-1:0]        tx_sr;
  logic [REG_WIDTH-1:0] rx_sr;
  logic                 cpol;
  logic                 cpha;

  logic          tick;
  logic          lead;
  logic          sample;
  logic          launch;
  logic          last_edge;
  logic [FB-1:0] frame;

  // tick marks the last cycle of each SCLK half-period.
  assign tick      = (div_cnt == DW'(CLK_DIV - 1));
  // edge_cnt holds edges already produced; the next one is edge_cnt+1,
  // which is a leading (odd) edge when edge_cnt is even.
  assign lead      = ~edge_cnt[0];
  assign last_edge = (edge_cnt == EW'(NE - 1));
  assign sample    = lead ^ cpha;
  // CPHA=0 launches on trailing edges except the final one (bit 0 must stay
  // valid through HOLD); CPHA=1 launches on every leading edge.
  assign launch    = cpha ? lead : (~lead & ~last_edge);
  assign frame     = {req_write, 7'(req_addr), (req_write ? req_wdata : {REG_WIDTH{1'b0}})};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      edge_cnt  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      cpol      <= 1'b0;
      cpha      <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      spi_cs_n  <= 1'b1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          spi_clk   <= mode[1];
          if (req_valid && req_ready) begin
            cpol      <= mode[1];
            cpha      <= mode[0];
            req_ready <= 1'b0;
            spi_cs_n  <= 1'b0;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            state     <= SETUP;
            if (mode[0]) begin
              tx_sr    <= frame;
              spi_mosi <= 1'b0;
            end else begin
              // CPHA=0: MSB must already be on the wire before the first edge.
              tx_sr    <= {frame[FB-2:0], 1'b0};
              spi_mosi <= frame[FB-1];
            end
          end
        end

        // SETUP ends with edge 1; SHIFT produces the rest.
        SETUP, SHIFT: begin
          div_cnt <= tick ? '0 : div_cnt + DW'(1);
          if (tick) begin
            spi_clk  <= ~spi_clk;
            edge_cnt <= edge_cnt + EW'(1);
            if (sample)
              rx_sr <= {rx_sr[REG_WIDTH-2:0], spi_miso};
            if (launch) begin
              spi_mosi <= tx_sr[FB-1];
              tx_sr    <= {tx_sr[FB-2:0], 1'b0};
            end
            state <= last_edge ? HOLD : SHIFT;
          end
        end

        HOLD: begin
          div_cnt <= tick ? '0 : div_cnt + DW'(1);
          if (tick) begin
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rx_sr;
            state     <= GAP;
          end
        end

        GAP: begin
          div_cnt <= tick ? '0 : div_cnt + DW'(1);
          spi_clk <= cpol;
          if (tick) begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller_master.sv
// tb_spi_controller_master
//   Drives register requests into spi_controller_master, models the SPI
//   peripheral side (mode-aware MISO launch, MOSI capture on sample edges)
//   and compares frame contents, response data and cycle timing against
//   values computed from the frame-level rules.
module tb_spi_controller_master;
  localparam int D  = 4;
  localparam int RW = 8;
  localparam int AW = 3;
  localparam int FB = 8 + RW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [RW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, spi_cs_n, spi_clk, spi_mosi, spi_miso;
  logic [RW-1:0] rsp_rdata;
  logic          periph_miso = 1'b0;
  logic          loopback = 1'b0;

  assign spi_miso = loopback ? spi_mosi : periph_miso;

  spi_controller_master #(.CLK_DIV(D), .REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  // Peripheral model: updates on the falling clk edge, the task side acts at +1.
  logic [1:0]    cur_mode = 2'd0;
  logic [FB-1:0] miso_word = '0;
  logic [FB-1:0] mosi_word = '0;
  logic          prev_cs = 1'b1;
  logic          prev_clk = 1'b0;
  logic          lead_m;
  int            edges = 0, samples = 0, miso_idx = 0, rsp_cnt = 0, frames = 0;
  int            cs_high_run = 0, first_edge = 0, last_edge = 0;

  always @(negedge clk) begin
    if (rsp_valid) rsp_cnt++;
    if (prev_cs && !spi_cs_n) begin
      if (frames > 0) chk("cs_gap", 32'(cs_high_run >= D), 1);
      frames++;
      edges = 0;
      samples = 0;
      mosi_word = '0;
      if (!cur_mode[0]) begin
        periph_miso = miso_word[FB-1];
        miso_idx = FB - 2;
      end else begin
        miso_idx = FB - 1;
      end
    end else if (!spi_cs_n && spi_clk != prev_clk) begin
      edges++;
      if (edges == 1) first_edge = cyc;
      last_edge = cyc;
      lead_m = (spi_clk != cur_mode[1]);
      if (lead_m ^ cur_mode[0]) begin
        mosi_word = {mosi_word[FB-2:0], spi_mosi};
        samples++;
      end else if (miso_idx >= 0) begin
        periph_miso = miso_word[miso_idx];
        miso_idx--;
      end
    end
    cs_high_run = spi_cs_n ? cs_high_run + 1 : 0;
    prev_cs = spi_cs_n;
    prev_clk = spi_clk;
  end

  int last_acc = 0;

  // One request. b2b: issue immediately (expect acceptance right at GAP end).
  // hv: keep req_valid high while busy. flip: new mode value applied mid-frame.
  // abort_e: assert rst once that many SCLK edges have been seen.
  task automatic do_txn(input logic [1:0] m, input logic w, input logic [AW-1:0] a,
                        input logic [RW-1:0] d, input logic [FB-1:0] mw, input logic lb,
                        input logic b2b, input logic hv, input logic do_flip,
                        input logic [1:0] flipm, input int abort_e);
    int acc, t, r0;
    logic [FB-1:0] exp_frame;
    logic [RW-1:0] exp_rd;
    exp_frame = {w, 7'(a), (w ? d : 8'h00)};
    exp_rd    = lb ? exp_frame[RW-1:0] : mw[RW-1:0];
    mode = m; loopback = lb; miso_word = mw; cur_mode = m;
    if (!b2b) begin
      step; step;
      chk("idle_clk", spi_clk, m[1]);
    end
    req_write = w; req_addr = a; req_wdata = w ? d : '0; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 400) begin step; t++; end
    r0 = rsp_cnt;
    step;
    acc = cyc;
    if (!hv) req_valid = 1'b0;
    if (b2b) chk("b2b_accept", acc - last_acc, (2*FB+2)*D + 1);
    chk("cs_fall", spi_cs_n, 0);
    chk("ready_low", req_ready, 0);
    t = 0;
    while (!rsp_valid && t < 1000) begin
      step; t++;
      if (do_flip && cyc == acc + 40) mode = flipm;
      if (abort_e != 0 && edges == abort_e && !spi_cs_n) begin
        #1 rst = 1'b1;
        #1;
        chk("abort_cs", spi_cs_n, 1);
        chk("abort_clk", spi_clk, 0);
        chk("abort_mosi", spi_mosi, 0);
        chk("abort_rsp", rsp_valid, 0);
        req_valid = 1'b0;
        step; step; step;
        rst = 1'b0;
        step;
        chk("abort_ready", req_ready, 1);
        step;
        chk("abort_norsp", rsp_cnt - r0, 0);
        last_acc = acc;
        return;
      end
    end
    chk("rsp_time", cyc - acc, (2*FB+1)*D);
    chk("rsp_cs", spi_cs_n, 1);
    chk("end_clk", spi_clk, m[1]);
    chk("rdata", rsp_rdata, exp_rd);
    chk("mosi", mosi_word, exp_frame);
    chk("samples", samples, FB);
    chk("edges", edges, 2*FB);
    chk("first_edge", first_edge - acc, D);
    chk("last_edge", last_edge - acc, 2*FB*D);
    req_valid = 1'b0;
    step;
    chk("rsp_pulse", rsp_valid, 0);
    t = 0;
    while (!req_ready && t < 100) begin step; t++; end
    chk("ready_time", cyc - acc, (2*FB+2)*D);
    chk("rsp_count", rsp_cnt - r0, 1);
    chk("gap_clk", spi_clk, m[1]);
    last_acc = acc;
    if (do_flip) begin
      step;
      chk("idle_new", spi_clk, flipm[1]);
    end
  endtask

  initial begin
    step; step;
    chk("rst_cs", spi_cs_n, 1);
    chk("rst_clk", spi_clk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_ready", req_ready, 0);
    rst = 1'b0;
    step;
    chk("ready_after_rst", req_ready, 1);

    // Write addr 3, 0xA5, mode 0: MOSI frame 0x83A5.
    do_txn(2'd0, 1'b1, 3'd3, 8'hA5, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0);
    // Read addr 7 in mode 3, peripheral returns 0x5A.
    do_txn(2'd3, 1'b0, 3'd7, 8'h00, 16'hC35A, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0);
    // Loopback write 0x3C in every mode.
    for (int m = 0; m < 4; m++)
      do_txn(2'(m), 1'b1, 3'd5, 8'h3C, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0);
    // Two requests with req_valid held while busy; second accepted at GAP end.
    do_txn(2'd2, 1'b1, 3'd1, 8'h96, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0);
    do_txn(2'd2, 1'b0, 3'd6, 8'h00, 16'h7E81, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 0);
    // Reset at SCLK edge 7, then a normal transaction.
    do_txn(2'd0, 1'b1, 3'd7, 8'hFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 7);
    do_txn(2'd0, 1'b1, 3'd2, 8'h4B, 16'h00D2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0);
    // Mode changed mid-frame 1 -> 2.
    do_txn(2'd1, 1'b1, 3'd4, 8'hC7, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 0);
    // Randomized transactions.
    for (int i = 0; i < 10; i++) begin
      logic w;
      w = 1'($urandom_range(0, 1));
      do_txn(2'($urandom_range(0, 3)), w, 3'($urandom_range(0, 7)), 8'($urandom),
             16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 2'd0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
